ufm_read: RTL and testbench
===========================

UFM_READ -- requirements
Module: ufm_read

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles to wait for readdatavalid per word (range 1..255).
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to load all configuration words from UFM.
REQ-005 ufmread  output  1  UFM Avalon-MM data read strobe.
REQ-006 read_addr  output  16  UFM word address, valid while ufmread=1.
REQ-007 waitrequest  input  1  UFM busy; a read is accepted on a cycle with ufmread=1 and waitrequest=0.
REQ-008 readdatavalid  input  1  qualifies readdata.
REQ-009 readdata  input  32  UFM read word.
REQ-010 program_data  output  8 x [21:0]  unpacked configuration bytes, same map as the UFM writer.
REQ-011 busy  output  1  high from the cycle after an accepted start until DONE or ERROR.
REQ-012 loaddone  output  1  held high after all six words are captured.
REQ-013 loaderror  output  1  held high after a readdatavalid timeout.
REQ-014 blank  output  1  word 0 read as 32'hFFFFFFFF (erased flash).

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, DONE, ERROR; word index idx SHALL be 3 bits, 0..5.
REQ-016 start SHALL be accepted only in IDLE, DONE or ERROR; accepting it SHALL clear idx, loaddone, loaderror and blank and enter REQ on the next cycle.
REQ-017 start in REQ or WAIT SHALL be ignored.
REQ-018 In REQ: ufmread=1 and read_addr={13'b0,idx}; ufmread SHALL hold while waitrequest=1.
REQ-019 On acceptance, the next cycle SHALL have ufmread=0, enter WAIT, and clear the timeout counter.
REQ-020 In WAIT with readdatavalid=1, the word SHALL be unpacked that cycle; then idx<5 -> idx+1, REQ; idx=5 -> DONE.
REQ-021 readdatavalid outside WAIT SHALL be ignored.
REQ-022 Unpack map, with [a:b] taken from readdata:
  word 0: [31:24]->pd21, [15:8]->pd1, [7:0]->pd0; [23:16] discarded.
  word 1: [23:16]->pd4, [15:8]->pd3, [7:0]->pd2; [31:24] discarded.
  word 2: [31:24]->pd8, [23:16]->pd7, [15:8]->pd6, [7:0]->pd5.
  word 3: pd12..pd9; word 4: pd16..pd13; word 5: pd20..pd17 (MSB byte to highest index).
REQ-023 Only the bytes mapped for the current word SHALL change on capture; all other program_data bytes SHALL hold.
REQ-024 blank SHALL be set when word 0 is captured and equals 32'hFFFFFFFF; program_data is still written.
REQ-025 In WAIT, the timeout counter SHALL increment each cycle without readdatavalid.
REQ-026 When the counter reaches TIMEOUT_CYCLES, the block SHALL enter ERROR; readdatavalid on that same cycle SHALL win, and the word SHALL be captured.
REQ-027 In DONE, loaddone=1; in ERROR, loaderror=1; busy=0 in both. ufmread=0 in IDLE, WAIT, DONE and ERROR.
REQ-028 Total latency with waitrequest=0 and readdatavalid one cycle after acceptance SHALL be 13 cycles from start to loaddone=1.

Reset
REQ-029 reset=1 SHALL force IDLE, idx=0, counter=0, ufmread=0, read_addr=0, busy=0, loaddone=0, loaderror=0, blank=0, and all program_data bytes=8'h00, including mid-transfer.
REQ-030 reset SHALL take priority over a simultaneous start.

Verification
REQ-031 Words 0..5 = 32'hAA00_0201, 32'h0005_0403, 32'h0908_0706, 32'h0D0C_0B0A, 32'h1110_0F0E, 32'h1514_1312, no waitrequest -> pd0..pd20 = 01..15 hex, pd21=AA, loaddone at cycle 13, blank=0.
REQ-032 waitrequest high for 4 cycles on word 3 -> ufmread and read_addr=3 held stable for those 4 cycles; final data identical to REQ-031.
REQ-033 Word 0 = 32'hFFFFFFFF -> blank=1, pd0=pd1=pd21=8'hFF, load completes with loaddone=1.
REQ-034 TIMEOUT_CYCLES=8, no readdatavalid on word 2 -> loaderror=1 after 8 WAIT cycles, busy=0, pd5..pd8 unchanged; a new start then completes normally.
REQ-035 reset asserted in WAIT of word 4 -> all outputs at reset values the next cycle; a late readdatavalid is ignored.
REQ-036 start pulsed during REQ -> ignored, single load completes, ufmread never asserted twice for the same idx.

Source files
------------

// File: rtl/ufm_read.sv
// Loads six configuration words from the UFM over Avalon-MM and unpacks them
// into 22 program bytes. Each read is issued, acknowledged, and then waited on with a timeout.
module ufm_read #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ufmread,
    output logic [15:0] read_addr,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [31:0] readdata,
    output logic [7:0]  program_data [0:21],
    output logic        busy,
    output logic        loaddone,
    output logic        loaderror,
    output logic        blank
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [2:0]  idx_reg;
    logic [7:0]  cnt_reg;
    logic        ufmread_reg;
    logic [15:0] read_addr_reg;
    logic        busy_reg;
    logic        loaddone_reg;
    logic        loaderror_reg;
    logic        blank_reg;
    logic        capture;

    assign capture   = (state_reg == S_WAIT) && readdatavalid;
    assign ufmread   = ufmread_reg;
    assign read_addr = read_addr_reg;
    assign busy      = busy_reg;
    assign loaddone  = loaddone_reg;
    assign loaderror = loaderror_reg;
    assign blank     = blank_reg;

    // Word index that feeds byte b (same layout the UFM writer uses).
    function automatic int byte_word(input int b);
        if (b == 0 || b == 1 || b == 21) return 0;
        if (b <= 4) return 1;
        return 2 + (b - 5) / 4;
    endfunction

    // Byte lane within that word.
    function automatic int byte_lane(input int b);
        if (b == 21) return 3;
        if (b <= 1) return b;
        if (b <= 4) return b - 2;
        return (b - 5) % 4;
    endfunction

    generate
        for (genvar gi = 0; gi < 22; gi++) begin : g_byte
            localparam logic [2:0] WORD = 3'(byte_word(gi));
            localparam int         LANE = byte_lane(gi);
            logic [7:0] byte_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    byte_reg <= 8'h00;
                end else if (capture && idx_reg == WORD) begin
                    byte_reg <= readdata[8*LANE +: 8];
                end
            end

            assign program_data[gi] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            idx_reg       <= 3'd0;
            cnt_reg       <= 8'd0;
            ufmread_reg   <= 1'b0;
            read_addr_reg <= 16'd0;
            busy_reg      <= 1'b0;
            loaddone_reg  <= 1'b0;
            loaderror_reg <= 1'b0;
            blank_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_reg     <= S_REQ;
                        idx_reg       <= 3'd0;
                        ufmread_reg   <= 1'b1;
                        read_addr_reg <= 16'd0;
                        busy_reg      <= 1'b1;
                        loaddone_reg  <= 1'b0;
                        loaderror_reg <= 1'b0;
                        blank_reg     <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!waitrequest) begin
                        state_reg   <= S_WAIT;
                        ufmread_reg <= 1'b0;
                        cnt_reg     <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // A word arriving on the final timeout cycle is still taken.
                    if (readdatavalid) begin
                        if (idx_reg == 3'd0 && readdata == 32'hFFFF_FFFF) begin
                            blank_reg <= 1'b1;
                        end
                        if (idx_reg == 3'd5) begin
                            state_reg    <= S_DONE;
                            busy_reg     <= 1'b0;
                            loaddone_reg <= 1'b1;
                        end else begin
                            state_reg     <= S_REQ;
                            idx_reg       <= idx_reg + 3'd1;
                            ufmread_reg   <= 1'b1;
                            read_addr_reg <= {13'b0, idx_reg + 3'd1};
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg     <= S_ERROR;
                        busy_reg      <= 1'b0;
                        loaderror_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ufm_read.sv
// Randomised bench for ufm_read: a UFM responder model, a byte-map reference
// model and a scoreboard that checks each load as busy falls.
module tb_ufm_read;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ufmread;
    logic [15:0] read_addr;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] readdata;
    logic [7:0]  program_data [0:21];
    logic        busy;
    logic        loaddone;
    logic        loaderror;
    logic        blank;

    always #5 clk = ~clk;

    ufm_read #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ufmread       (ufmread),
        .read_addr     (read_addr),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .readdata      (readdata),
        .program_data  (program_data),
        .busy          (busy),
        .loaddone      (loaddone),
        .loaderror     (loaderror),
        .blank         (blank)
    );

    typedef struct packed {
        logic             done;
        logic             err;
        logic             blank;
        logic [21:0][7:0] pd;
    } exp_t;

    exp_t exp_q[$];
    logic [21:0][7:0] model_pd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder configuration and state
    logic [31:0] words [6];
    int          stall [6];
    int          delay [6];   // 0 = never answers
    int          stall_seen [6];
    int          next_idx;
    int          stall_left;
    int          pend_cnt;
    logic [31:0] pend_data;
    bit          outstanding;
    bit          holding;
    bit          spurious_en;
    int          accept_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int dest(input int w, input int l);
        if (w == 0) return (l == 0) ? 0 : (l == 1) ? 1 : (l == 3) ? 21 : -1;
        if (w == 1) return (l == 3) ? -1 : 2 + l;
        return 5 + 4 * (w - 2) + l;
    endfunction

    // UFM responder: decides waitrequest and returns data after delay[] cycles.
    initial begin : responder
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        pend_cnt      = 0;
        outstanding   = 1'b0;
        holding       = 1'b0;
        forever begin
            @(negedge clk);
            readdatavalid = 1'b0;
            readdata      = $urandom;
            waitrequest   = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    readdatavalid = 1'b1;
                    readdata      = pend_data;
                    outstanding   = 1'b0;
                end
            end else if (spurious_en && !outstanding && $urandom_range(0, 3) == 0) begin
                readdatavalid = 1'b1;
            end
            if (holding) check("ufmread_held", ufmread, 1);
            holding = 1'b0;
            if (ufmread === 1'b1) begin
                if (next_idx > 5) begin
                    check("extra_read", read_addr, 16'hFFFF);
                end else begin
                    check("read_addr", read_addr, next_idx);
                    if (stall_left > 0) begin
                        waitrequest = 1'b1;
                        stall_left--;
                        holding = 1'b1;
                        stall_seen[next_idx]++;
                    end else begin
                        accept_cyc  = cyc;
                        outstanding = 1'b1;
                        if (delay[next_idx] > 0) begin
                            pend_cnt  = delay[next_idx];
                            pend_data = words[next_idx];
                        end
                        next_idx++;
                        stall_left = (next_idx < 6) ? stall[next_idx] : 0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every busy fall ends a load (or a reset) and is checked.
    initial begin : monitor
        exp_t e;
        bit   prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_end", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("loaddone", loaddone, e.done);
                    check("loaderror", loaderror, e.err);
                    check("blank", blank, e.blank);
                    for (int i = 0; i < 22; i++)
                        check($sformatf("pd%0d", i), program_data[i], e.pd[i]);
                    if (e.err && !reset) check("timeout_gap", cyc - accept_cyc, T + 1);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic set_nominal();
        words[0] = 32'hAA00_0201; words[1] = 32'h0005_0403; words[2] = 32'h0908_0706;
        words[3] = 32'h0D0C_0B0A; words[4] = 32'h1110_0F0E; words[5] = 32'h1514_1312;
        for (int w = 0; w < 6; w++) begin
            stall[w] = 0;
            delay[w] = 1;
        end
    endtask

    // Expected outcome from the byte map, then one start pulse and a bounded wait.
    task automatic do_load(input bit extra_start, output int lat);
        exp_t e;
        int   n;
        e.done  = 1'b1;
        e.err   = 1'b0;
        e.blank = 1'b0;
        for (int w = 0; w < 6; w++) begin
            if (delay[w] == 0 || delay[w] > T) begin
                e.err  = 1'b1;
                e.done = 1'b0;
                break;
            end
            for (int l = 0; l < 4; l++)
                if (dest(w, l) >= 0) model_pd[dest(w, l)] = words[w][8*l +: 8];
            if (w == 0 && words[0] == 32'hFFFF_FFFF) e.blank = 1'b1;
        end
        e.pd = model_pd;
        exp_q.push_back(e);
        for (int w = 0; w < 6; w++) stall_seen[w] = 0;
        next_idx   = 0;
        stall_left = stall[0];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n     = 1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("flags_cleared", {loaddone, loaderror, blank}, 3'b000);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
            start = extra_start && busy && ($urandom_range(0, 2) == 0);
        end
        start = 1'b0;
        if (busy) check("load_timeout", busy, 0);
        lat = n;
        if (pend_cnt == 0) outstanding = 1'b0;
    endtask

    initial begin : main
        int lat;
        int k;
        exp_t rz;
        reset       = 1'b1;
        start       = 1'b0;
        spurious_en = 1'b0;
        model_pd    = '0;
        set_nominal();
        next_idx    = 0;
        stall_left  = 0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {ufmread, busy, loaddone, loaderror, blank}, 5'b0);
        check("rst_addr", read_addr, 0);
        for (int i = 0; i < 22; i++) check($sformatf("rst_pd%0d", i), program_data[i], 0);
        reset = 1'b0;
        spurious_en = 1'b1;

        // Nominal load: data map and start-to-loaddone latency
        do_load(1'b0, lat);
        $display("load nominal latency=%0d", lat);
        check("latency", lat, 13);

        // Stall on word 3
        set_nominal();
        stall[3] = 4;
        do_load(1'b0, lat);
        $display("load stall word3 stall_cycles=%0d", stall_seen[3]);
        check("stall_cycles_w3", stall_seen[3], 4);

        // Erased flash
        set_nominal();
        words[0] = 32'hFFFF_FFFF;
        do_load(1'b0, lat);
        $display("load blank word0");

        // Timeout on word 2, then a normal reload
        set_nominal();
        delay[2] = 0;
        do_load(1'b0, lat);
        $display("load timeout word2");
        set_nominal();
        do_load(1'b0, lat);
        $display("load recovery after error");

        // Data on the last allowed cycle wins; one cycle later is too late
        set_nominal();
        delay[4] = T;
        do_load(1'b0, lat);
        $display("load boundary delay=%0d", T);
        set_nominal();
        delay[1] = T + 1;
        do_load(1'b0, lat);
        $display("load late delay=%0d", T + 1);

        // Extra start pulses during the load are ignored
        set_nominal();
        words[5] = 32'h5A5A_C3C3;
        do_load(1'b1, lat);
        $display("load with extra starts");

        // Reset in WAIT of word 4 with a late answer pending
        set_nominal();
        delay[4] = 5;
        rz = '0;
        exp_q.push_back(rz);
        model_pd = '0;
        next_idx   = 0;
        stall_left = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(outstanding && next_idx == 5) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("reach_word4", 0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_ufmread", ufmread, 0);
        check("rst_mid_addr", read_addr, 0);
        repeat (8) @(negedge clk);
        check("late_rdv_ignored", {busy, loaddone, loaderror, blank}, 4'b0);
        for (int i = 0; i < 22; i++) check($sformatf("post_rst_pd%0d", i), program_data[i], 0);
        outstanding = 1'b0;
        $display("reset during word4 wait");

        // Reset wins over a simultaneous start
        set_nominal();
        do_load(1'b0, lat);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        model_pd = '0;
        check("rst_over_start", {busy, ufmread, loaddone}, 3'b000);
        @(negedge clk);
        check("rst_over_start_idle", busy, 0);
        $display("reset with simultaneous start");

        // Randomised loads
        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < 6; w++) begin
                words[w] = $urandom;
                stall[w] = $urandom_range(0, 2);
                delay[w] = $urandom_range(1, T);
            end
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 5);
                delay[k] = ($urandom_range(0, 1) == 0) ? 0 : T + 1;
            end
            if ($urandom_range(0, 4) == 0) words[0] = 32'hFFFF_FFFF;
            do_load(1'($urandom_range(0, 1)), lat);
            $display("load random %0d cycles=%0d", r, lat);
        end

        repeat (12) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
